// File: rtl/ks10_bus_pkg.sv
// Shared KS10 bus definitions: address flag bit positions and the
// bus-timeout monitor state encoding.
package ks10_bus_pkg;

  localparam int ADDR_W   = 36;
  localparam int FLAG_IO  = 3;
  localparam int FLAG_WRU = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TOUT = 2'd2,
    DONE = 2'd3
  } tmo_state_t;

endpackage

// File: rtl/bus_timeout_mon.sv
// CPU bus cycle watchdog: forces a one-clock acknowledge when no device
// answers within TIMEOUT clocks and records NXM/NXD plus the failing address.
module bus_timeout_mon
  import ks10_bus_pkg::*;
#(
  parameter int TIMEOUT = 127,
  parameter int CNTW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          busREQ,
  input  logic          busACK,
  input  logic [0:35]   busADDR,
  input  logic          clrERR,
  output logic          toACK,
  output logic          nxmERR,
  output logic          nxdERR,
  output logic [0:35]   errADDR,
  output logic          busy
);

  tmo_state_t       state_q, state_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [0:35]      cur_addr_q, cur_addr_d;
  logic             to_ack_q, to_ack_d;
  logic             busy_q, busy_d;
  logic             nxm_q, nxm_d;
  logic             nxd_q, nxd_d;
  logic [0:35]      err_addr_q, err_addr_d;
  logic             timeout_hit;

  assign timeout_hit = (count_q == CNTW'(TIMEOUT));

  // Cycle counter: starts at 1 on the request clock, saturates at TIMEOUT
  always_comb begin
    count_d = count_q;
    case (state_q)
      IDLE:    count_d = busREQ ? CNTW'(1) : '0;
      WAIT:    if (!timeout_hit) count_d = count_q + CNTW'(1);
      default: count_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  // Cycle FSM; a real acknowledge takes priority over an expiring count
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    case (state_q)
      IDLE: begin
        if (busREQ) begin
          state_d    = WAIT;
          cur_addr_d = busADDR;
        end
      end
      WAIT: begin
        if (busACK)           state_d = DONE;
        else if (!busREQ)     state_d = IDLE;
        else if (timeout_hit) state_d = TOUT;
      end
      TOUT:    state_d = DONE;
      DONE:    if (!busREQ) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d == WAIT);
    to_ack_d = (state_d == TOUT);
  end

  always_ff @(posedge clk) begin
    cur_addr_q <= cur_addr_d;
    if (rst) begin
      state_q  <= IDLE;
      to_ack_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_ack_q <= to_ack_d;
      busy_q   <= busy_d;
    end
  end

  // Sticky error capture; a timeout in the same clock as clrERR still sets
  always_comb begin
    nxm_d      = clrERR ? 1'b0 : nxm_q;
    nxd_d      = clrERR ? 1'b0 : nxd_q;
    err_addr_d = clrERR ? '0   : err_addr_q;
    if (state_q == TOUT && !cur_addr_q[FLAG_WRU]) begin
      if (!(nxm_q || nxd_q) || clrERR) err_addr_d = cur_addr_q;
      if (cur_addr_q[FLAG_IO]) nxd_d = 1'b1;
      else                     nxm_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nxm_q      <= 1'b0;
      nxd_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      nxm_q      <= nxm_d;
      nxd_q      <= nxd_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign toACK   = to_ack_q;
  assign busy    = busy_q;
  assign nxmERR  = nxm_q;
  assign nxdERR  = nxd_q;
  assign errADDR = err_addr_q;

endmodule

// File: tb/tb_bus_timeout_mon.sv
// Scoreboard bench for bus_timeout_mon: each bus cycle pushes its expected
// outcome; a monitor pops it when busy falls and checks flags one clock later.
module tb_bus_timeout_mon;

  logic        clk = 1'b0;
  logic        rst;
  logic        busREQ;
  logic        busACK;
  logic [0:35] busADDR;
  logic        clrERR;
  logic        toACK;
  logic        nxmERR;
  logic        nxdERR;
  logic [0:35] errADDR;
  logic        busy;

  bus_timeout_mon #(.TIMEOUT(127), .CNTW(7)) dut (
    .clk     (clk),
    .rst     (rst),
    .busREQ  (busREQ),
    .busACK  (busACK),
    .busADDR (busADDR),
    .clrERR  (clrERR),
    .toACK   (toACK),
    .nxmERR  (nxmERR),
    .nxdERR  (nxdERR),
    .errADDR (errADDR),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    bit          toack;
    bit          nxm;
    bit          nxd;
    logic [0:35] err;
  } exp_t;

  exp_t sb[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   n_toack = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  // Monitor: a falling busy marks the end of a timed cycle
  bit   busy_prev = 1'b0;
  bit   pend      = 1'b0;
  bit   fall_toack;
  int   blen      = 0;
  int   fall_len;
  exp_t e_mon;

  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      if (sb.size() == 0) begin
        chk("unexpected_cycle_end", 64'd1, 64'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("busy_len", 64'(fall_len), 64'(e_mon.len));
        chk("toack",    64'(fall_toack), 64'(e_mon.toack));
        chk("nxmERR",   64'(nxmERR), 64'(e_mon.nxm));
        chk("nxdERR",   64'(nxdERR), 64'(e_mon.nxd));
        chk("errADDR",  64'(errADDR), 64'(e_mon.err));
      end
    end
    if (toACK === 1'b1) n_toack++;
    if (busy === 1'b1) begin
      blen++;
    end else if (busy_prev) begin
      pend       = 1'b1;
      fall_toack = (toACK === 1'b1);
      fall_len   = blen;
      blen       = 0;
    end
    busy_prev = (busy === 1'b1);
  end

  // One CPU bus cycle. Clock numbers count posedges from the first one that
  // samples busREQ high; 0 disables an event.
  task automatic bus_cycle(input logic [0:35] addr, input int ack_clk, input int drop_clk,
                           input int rst_clk, input bit clr_tout, input bit late_ack,
                           input exp_t e);
    int c;
    bit done;
    sb.push_back(e);
    busADDR = addr;
    busREQ  = 1'b1;
    c       = 1;
    done    = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (c > 200) begin
        chk("cycle_bound", 64'(c), 64'd200);
        busREQ = 1'b0; busACK = 1'b0; rst = 1'b0;
        done   = 1'b1;
      end else if (toACK === 1'b1) begin
        clrERR = clr_tout;
        @(negedge clk);
        clrERR = 1'b0;
        busACK = late_ack;
        @(negedge clk);
        busACK = 1'b0;
        busREQ = 1'b0;
        done   = 1'b1;
      end else begin
        c++;
        if (c == 3)        busADDR = ~addr;
        if (c == ack_clk)  busACK  = 1'b1;
        if (c == drop_clk) busREQ  = 1'b0;
        if (c == rst_clk)  rst     = 1'b1;
        if (c == ack_clk + 1 || c == drop_clk + 1 || c == rst_clk + 1) begin
          busACK = 1'b0;
          busREQ = 1'b0;
          rst    = 1'b0;
          done   = 1'b1;
        end
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_err();
    @(negedge clk);
    clrERR = 1'b1;
    @(negedge clk);
    clrERR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    busREQ  = 1'b0;
    busACK  = 1'b0;
    busADDR = '0;
    clrERR  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_toACK",   64'(toACK),   64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_nxmERR",  64'(nxmERR),  64'd0);
    chk("rst_nxdERR",  64'(nxdERR),  64'd0);
    chk("rst_errADDR", 64'(errADDR), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // memory read acknowledged on the 5th WAIT clock
    bus_cycle(36'o000000_001000, 6, 0, 0, 1'b0, 1'b0, '{5, 1'b0, 1'b0, 1'b0, 36'o0});
    // memory read never acknowledged
    bus_cycle(36'o000000_001000, 0, 0, 0, 1'b0, 1'b0,
              '{127, 1'b1, 1'b1, 1'b0, 36'o000000_001000});
    clear_err();
    // IO reads time out; the second keeps the first address
    bus_cycle(36'o040000_776000, 0, 0, 0, 1'b0, 1'b0,
              '{127, 1'b1, 1'b0, 1'b1, 36'o040000_776000});
    bus_cycle(36'o040000_777000, 0, 0, 0, 1'b0, 1'b0,
              '{127, 1'b1, 1'b0, 1'b1, 36'o040000_776000});
    clear_err();
    // WRU poll times out silently; a late ack in DONE is ignored
    bus_cycle(36'o020000_000100, 0, 0, 0, 1'b0, 1'b1, '{127, 1'b1, 1'b0, 1'b0, 36'o0});
    // ack arrives in the same clock the count reaches TIMEOUT
    bus_cycle(36'o000000_002000, 128, 0, 0, 1'b0, 1'b0, '{127, 1'b0, 1'b0, 1'b0, 36'o0});
    bus_cycle(36'o000000_004000, 0, 0, 0, 1'b0, 1'b0,
              '{127, 1'b1, 1'b1, 1'b0, 36'o000000_004000});
    // clrERR during TOUT: set wins and the new address is taken
    bus_cycle(36'o000000_003000, 0, 0, 0, 1'b1, 1'b0,
              '{127, 1'b1, 1'b1, 1'b0, 36'o000000_003000});
    // reset at count 60 aborts the cycle and clears the error state
    bus_cycle(36'o000000_005000, 0, 0, 61, 1'b0, 1'b0, '{60, 1'b0, 1'b0, 1'b0, 36'o0});
    // request dropped mid-WAIT
    bus_cycle(36'o040000_001000, 0, 11, 0, 1'b0, 1'b0, '{10, 1'b0, 1'b0, 1'b0, 36'o0});

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("toack_total",      64'(n_toack),   64'd6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
